// File: rtl/axi_to_mac_tx_buffer_if.sv
// AXI4-Lite write-channel bundle between a register master and the MAC TX buffer.
interface axi_to_mac_tx_buffer_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
  );
endinterface

// File: rtl/axi_to_mac_tx_buffer.sv
// Packet buffer loaded over AXI4-Lite; a CTRL length write streams the packet
// onto the tri-mode MAC user TX interface with SOP/EOP/byte-enable framing.
module axi_to_mac_tx_buffer #(
  parameter int _dat_w_mac         = 32,
  parameter int _ben_w_mac         = 2,
  parameter int _addr_w_mem        = 9,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axi_to_mac_tx_buffer_if.slave  s_axi,
  input  logic                   mac_txwa_i,
  output logic                   mac_txwr_o,
  output logic [_dat_w_mac-1:0]  mac_txd_o,
  output logic [_ben_w_mac-1:0]  mac_txben_o,
  output logic                   mac_txsop_o,
  output logic                   mac_txeop_o,
  output logic                   tx_busy_o,
  output logic [31:0]            tx_pkt_count_o
);

  localparam int L_DEPTH = 1 << _addr_w_mem;
  localparam int L_LW    = _addr_w_mem + 2;
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] L_CTRL_ADDR = C_S_AXI_ADDR_WIDTH'(1) << L_LW;
  localparam logic [31:0] L_MAX_LEN = 32'(4 * L_DEPTH);
  localparam logic [1:0]  L_OKAY    = 2'b00;
  localparam logic [1:0]  L_SLVERR  = 2'b10;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

  tx_state_t r_state;
  tx_state_t w_state_nxt;

  logic                          r_ready;
  logic                          r_bvalid;
  logic [1:0]                    r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [L_DEPTH];
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [_addr_w_mem-1:0]        r_idx;
  logic [_addr_w_mem-1:0]        r_last_idx;
  logic [1:0]                    r_lastben;
  logic [31:0]                   r_count;

  logic                   w_wr;
  logic                   w_is_buf;
  logic                   w_is_ctrl;
  logic                   w_len_ok;
  logic                   w_busy;
  logic                   w_buf_wr;
  logic                   w_ctrl_start;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_rd_en;
  logic [15:0]            w_len;
  logic [L_LW-1:0]        w_len_m1;
  logic [_addr_w_mem-1:0] w_wr_addr;
  logic [_addr_w_mem-1:0] w_rd_addr;

  assign w_busy       = (r_state != TX_IDLE);
  assign w_wr         = r_ready & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign w_is_buf     = (s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:L_LW] == '0);
  assign w_is_ctrl    = (s_axi.S_AXI_AWADDR == L_CTRL_ADDR);
  assign w_len        = s_axi.S_AXI_WDATA[15:0];
  assign w_len_ok     = (w_len != 16'd0) && ({16'd0, w_len} <= L_MAX_LEN);
  // LEN-1 yields both the last word index (ceil(LEN/4)-1) and the EOP byte-enable code.
  assign w_len_m1     = w_len[L_LW-1:0] - L_LW'(1);
  assign w_wr_addr    = s_axi.S_AXI_AWADDR[L_LW-1:2];
  assign w_buf_wr     = w_wr & w_is_buf & ~w_busy;
  assign w_ctrl_start = w_wr & w_is_ctrl & w_len_ok & ~w_busy;

  assign w_xfer    = (r_state == TX_SEND) & mac_txwa_i;
  assign w_last    = (r_idx == r_last_idx);
  assign w_rd_en   = (r_state == TX_LOAD) | w_xfer;
  assign w_rd_addr = (r_state == TX_LOAD) ? '0 : r_idx + _addr_w_mem'(1);

  assign s_axi.S_AXI_AWREADY = r_ready;
  assign s_axi.S_AXI_WREADY  = r_ready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign tx_busy_o           = w_busy;
  assign tx_pkt_count_o      = r_count;
  assign mac_txwr_o          = w_xfer;

  // Block RAM: byte-enabled write port, registered read port that only advances on a transfer.
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_buf_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) r_mem[w_wr_addr][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
    if (w_rd_en) r_rdata <= r_mem[w_rd_addr];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= TX_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE: if (w_ctrl_start) w_state_nxt = TX_LOAD;
      TX_LOAD: w_state_nxt = TX_SEND;
      TX_SEND: if (w_xfer && w_last) w_state_nxt = TX_IDLE;
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_ready    <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= L_OKAY;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_lastben  <= 2'b00;
      r_count    <= 32'd0;
    end else begin
      r_ready <= ~r_ready & ~r_bvalid & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_buf_wr | w_ctrl_start) ? L_OKAY : L_SLVERR;
      end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (w_ctrl_start) begin
        r_idx      <= '0;
        r_last_idx <= w_len_m1[L_LW-1:2];
        r_lastben  <= w_len_m1[1:0];
      end else if (w_xfer && !w_last) begin
        r_idx <= r_idx + _addr_w_mem'(1);
      end
      if (w_xfer && w_last) r_count <= r_count + 32'd1;
    end
  end

  // Framing is only driven in TX_SEND; bytes above the EOP byte-enable are forced to zero.
  always_comb begin
    mac_txd_o   = '0;
    mac_txsop_o = 1'b0;
    mac_txeop_o = 1'b0;
    mac_txben_o = '0;
    if (r_state == TX_SEND) begin
      mac_txsop_o = (r_idx == '0);
      mac_txeop_o = w_last;
      mac_txben_o = w_last ? r_lastben : 2'b11;
      for (int b = 0; b < 4; b++) begin
        if (!w_last || (2'(b) <= r_lastben)) mac_txd_o[8*b +: 8] = r_rdata[8*b +: 8];
      end
    end
  end

endmodule
